// File: rtl/reg_file_sb.sv
// reg_file_sb: dual-read/dual-write register file with per-register pending-write scoreboard.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data and readiness to the read ports.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int V0_INDEX   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  ready_a,
  output logic                  ready_b,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  input  logic                  claim_en,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  output logic                  claim_conflict,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic [DATA_WIDTH-1:0] register_v0
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;
  logic w0v, w1v, cv;
  assign w0v = wr0_en && wr0_addr != '0;
  assign w1v = wr1_en && wr1_addr != '0;
  assign cv = claim_en && claim_addr != '0;
  // a claim is a newer producer than any write landing in the same cycle
  always_comb begin
    busy_nxt = busy;
    if (w0v) busy_nxt[wr0_addr] = 1'b0;
    if (w1v) busy_nxt[wr1_addr] = 1'b0;
    if (cv) busy_nxt[claim_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt += (ADDR_WIDTH+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
      claim_conflict <= 1'b0;
      pending_count <= '0;
    end else begin
      if (w0v) regs[wr0_addr] <= wr0_data;
      if (w1v) regs[wr1_addr] <= wr1_data;
      busy <= busy_nxt;
      claim_conflict <= cv && busy[claim_addr];
      pending_count <= cnt_nxt;
    end
`ifdef REG_FILE_BYPASS_EN
  logic w0a, w1a, w0b, w1b;
  assign w0a = w0v && wr0_addr == addr_a;
  assign w1a = w1v && wr1_addr == addr_a;
  assign w0b = w0v && wr0_addr == addr_b;
  assign w1b = w1v && wr1_addr == addr_b;
  assign a = w1a ? wr1_data : w0a ? wr0_data : regs[addr_a];
  assign b = w1b ? wr1_data : w0b ? wr0_data : regs[addr_b];
  assign ready_a = !busy[addr_a] || ((w0a || w1a) && !(cv && claim_addr == addr_a));
  assign ready_b = !busy[addr_b] || ((w0b || w1b) && !(cv && claim_addr == addr_b));
`else
  assign a = regs[addr_a];
  assign b = regs[addr_b];
  assign ready_a = !busy[addr_a];
  assign ready_b = !busy[addr_b];
`endif
  assign register_v0 = regs[V0_INDEX];
endmodule
